// File: rtl/fetch_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen_pkg
// Brief    : Shared constants, output-queue entry type and address helpers
//            for the fetch PC generator.
// Revision : 1.0
// ============================================================================
package fetch_pc_gen_pkg;

    localparam logic [31:0] c_RESET_PC    = 32'h1c00_0000;
    localparam int          c_FETCH_BYTES = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
    } fetch_entry_t;

    function automatic logic [31:0] pair_addr(input logic [31:0] pc);
        return {pc[31:3], 3'b000};
    endfunction

    // A PC in the upper word of a pair leaves only slot a (the upper inst) valid.
    function automatic logic [1:0] slot_mask(input logic [31:0] pc);
        return pc[2] ? 2'b01 : 2'b11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small synchronous FIFO with push/pop/flush and occupancy count.
//            DEPTH must be a power of two.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == c_FULL);
    assign w_pop  = pop & ~empty & ~flush;
    assign w_push = push & ~flush & (~full | w_pop);
    assign head   = r_mem[r_rptr];
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
            r_count <= r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : Owns the fetch PC, issues 8-byte pair requests to the icache,
//            drops redirect-stale responses and queues pairs for the ibuf.
//            Define FETCH_PERF_CNT_EN to add redirect/drop counters.
// Revision : 1.0
// ============================================================================
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = c_RESET_PC,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        branch_mistaken,
    input  logic [31:0] correct_target,
    output logic        icache_req_valid,
    input  logic        icache_req_ready,
    output logic [31:0] icache_req_addr,
    input  logic        icache_resp_valid,
    input  logic [63:0] icache_resp_data,
    output logic        ibuf_valid,
    input  logic        ibuf_ready,
    output logic [31:0] ibuf_pc,
    output logic [63:0] ibuf_inst,
    output logic [1:0]  ibuf_mask
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_redirect_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam int              c_CW         = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [c_CW-1:0] c_MAX_INF    = c_CW'(MAX_INFLIGHT);
    localparam logic [c_CW:0]   c_MAX_OCC    = (c_CW+1)'(MAX_INFLIGHT);
    localparam logic [31:0]     c_FETCH_STEP = 32'(c_FETCH_BYTES);

    logic [31:0]     r_pc;
    logic [c_CW-1:0] r_inflight;
    logic [c_CW-1:0] r_drop_cnt;

    logic            w_redirect;
    logic [31:0]     w_tgt;
    logic [31:0]     w_req_tag;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_resp_fire;
    logic            w_dropping;
    logic [c_CW-1:0] w_live;
    logic [c_CW:0]   w_occupancy;

    logic [31:0]     w_tag_head;
    logic [c_CW-1:0] w_tag_count;
    logic            w_tag_empty;
    logic            w_tag_full;

    fetch_entry_t    w_oq_in;
    fetch_entry_t    w_oq_head;
    logic [c_CW-1:0] w_oq_count;
    logic            w_oq_empty;
    logic            w_oq_full;
    logic            w_oq_push;
    logic            w_oq_pop;

    assign w_redirect  = branch_mistaken;
    assign w_tgt       = correct_target & ~32'h3;
    assign w_req_tag   = w_redirect ? w_tgt : r_pc;
    assign w_dropping  = (r_drop_cnt != '0);
    assign w_live      = r_inflight - r_drop_cnt;
    assign w_occupancy = {1'b0, w_live} + {1'b0, w_oq_count};

    // Outstanding live requests plus queued pairs never exceed the queue depth,
    // so every accepted response has a slot waiting for it.
    assign w_req_valid = resetn & (w_occupancy < c_MAX_OCC) & (r_inflight < c_MAX_INF);
    assign w_req_fire  = w_req_valid & icache_req_ready;
    assign w_resp_fire = icache_resp_valid;

    assign icache_req_valid = w_req_valid;
    assign icache_req_addr  = resetn ? pair_addr(w_req_tag) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_inflight <= r_inflight + c_CW'(w_req_fire) - c_CW'(w_resp_fire);
            if (w_redirect) begin
                // A response landing this cycle is already stale; a request issued this cycle is not.
                r_pc       <= w_req_fire ? pair_addr(w_tgt) + c_FETCH_STEP : w_tgt;
                r_drop_cnt <= r_inflight - c_CW'(w_resp_fire);
            end else begin
                if (w_req_fire) r_pc <= pair_addr(r_pc) + c_FETCH_STEP;
                if (w_resp_fire && w_dropping) r_drop_cnt <= r_drop_cnt - c_CW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_req_fire),
        .push_data (w_req_tag),
        .pop       (w_resp_fire),
        .flush     (1'b0),
        .head      (w_tag_head),
        .count     (w_tag_count),
        .empty     (w_tag_empty),
        .full      (w_tag_full)
    );

    assign w_oq_in   = '{pc: w_tag_head, inst: icache_resp_data, mask: slot_mask(w_tag_head)};
    assign w_oq_push = w_resp_fire & ~w_dropping & ~w_redirect;
    assign w_oq_pop  = ibuf_valid & ibuf_ready;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (MAX_INFLIGHT)
    ) u_out_queue (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_oq_push),
        .push_data (w_oq_in),
        .pop       (w_oq_pop),
        .flush     (w_redirect),
        .head      (w_oq_head),
        .count     (w_oq_count),
        .empty     (w_oq_empty),
        .full      (w_oq_full)
    );

    assign ibuf_valid = ~w_oq_empty & ~w_redirect;
    assign ibuf_pc    = w_oq_empty ? '0 : w_oq_head.pc;
    assign ibuf_inst  = w_oq_empty ? '0 : w_oq_head.inst;
    assign ibuf_mask  = w_oq_empty ? '0 : w_oq_head.mask;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_redirect_cnt;
    logic [31:0] r_perf_drop_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_redirect_cnt <= '0;
            r_perf_drop_cnt     <= '0;
        end else begin
            if (w_redirect) r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
            if (w_resp_fire && (w_redirect || w_dropping)) r_perf_drop_cnt <= r_perf_drop_cnt + 32'd1;
        end
    end

    assign perf_redirect_cnt = r_perf_redirect_cnt;
    assign perf_drop_cnt     = r_perf_drop_cnt;
`endif

    a_oq_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(w_oq_push && w_oq_full && !w_oq_pop));
    a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (!resetn)
        (w_tag_count == r_inflight));
    a_resp_has_tag: assert property (@(posedge clk) disable iff (!resetn)
        !(w_resp_fire && w_tag_empty));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(w_req_fire && w_tag_full && !w_resp_fire));

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_gen
// Brief    : Directed self-checking bench for fetch_pc_gen with a small
//            in-order icache responder and an ibuf pop log.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_pc_gen;
    import fetch_pc_gen_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        branch_mistaken = 1'b0;
    logic [31:0] correct_target = '0;
    logic        icache_req_ready = 1'b0;
    logic        icache_resp_valid = 1'b0;
    logic [63:0] icache_resp_data = '0;
    logic        ibuf_ready = 1'b0;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        ibuf_valid;
    logic [31:0] ibuf_pc;
    logic [63:0] ibuf_inst;
    logic [1:0]  ibuf_mask;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirect_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    fetch_pc_gen #(
        .RESET_PC     (32'h1c00_0000),
        .MAX_INFLIGHT (2)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .branch_mistaken   (branch_mistaken),
        .correct_target    (correct_target),
        .icache_req_valid  (icache_req_valid),
        .icache_req_ready  (icache_req_ready),
        .icache_req_addr   (icache_req_addr),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .ibuf_valid        (ibuf_valid),
        .ibuf_ready        (ibuf_ready),
        .ibuf_pc           (ibuf_pc),
        .ibuf_inst         (ibuf_inst),
        .ibuf_mask         (ibuf_mask)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_drop_cnt     (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    pend_t        pend[$];
    logic [31:0]  reqs[$];
    fetch_entry_t got[$];
    logic [31:0]  cyc = '0;
    logic         resp_hold = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;

    function automatic logic [63:0] pair_data(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {~(b + 32'd4), ~b};
    endfunction

    always @(posedge clk) cyc <= cyc + 32'd1;

    // In-order icache with one-cycle latency; resp_hold freezes delivery.
    always @(posedge clk) begin
        if (!resetn) begin
            pend.delete();
            icache_resp_valid <= 1'b0;
        end else begin
            if (icache_resp_valid && pend.size() > 0) void'(pend.pop_front());
            if (icache_req_valid && icache_req_ready) begin
                pend.push_back({icache_req_addr, cyc});
                reqs.push_back(icache_req_addr);
            end
            if (pend.size() > 0 && !resp_hold && pend[0].due <= cyc) begin
                icache_resp_valid <= 1'b1;
                icache_resp_data  <= pair_data(pend[0].addr);
            end else begin
                icache_resp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (resetn && ibuf_valid && ibuf_ready) got.push_back({ibuf_pc, ibuf_inst, ibuf_mask});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag, input int k, input logic [31:0] pc, input logic [1:0] mask);
        fetch_entry_t e;
        e = '0;
        if (got.size() > k) e = got[k];
        check({tag, ".pc"}, 64'(e.pc), 64'(pc));
        check({tag, ".mask"}, 64'(e.mask), 64'(mask));
        check({tag, ".inst"}, e.inst, pair_data(pc));
    endtask

    task automatic check_req(input string tag, input int k, input logic [31:0] addr);
        logic [31:0] a;
        a = '0;
        if (reqs.size() > k) a = reqs[k];
        check(tag, 64'(a), 64'(addr));
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step(1);
            ok = (pend.size() == 0) && !icache_resp_valid && !ibuf_valid;
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic redirect_idle(input logic [31:0] tgt);
        branch_mistaken = 1'b1;
        correct_target  = tgt;
        step(1);
        branch_mistaken = 1'b0;
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst.req_valid", 64'(icache_req_valid), 64'd0);
        check("rst.req_addr", 64'(icache_req_addr), 64'd0);
        check("rst.ibuf_valid", 64'(ibuf_valid), 64'd0);
        check("rst.ibuf_pc", 64'(ibuf_pc), 64'd0);

        // 1: sequential fetch from RESET_PC
        icache_req_ready = 1'b1;
        ibuf_ready       = 1'b1;
        resetn           = 1'b1;
        step(12);
        icache_req_ready = 1'b0;
        wait_idle("t1.idle");
        check_req("t1.req0", 0, 32'h1c00_0000);
        check_req("t1.req1", 1, 32'h1c00_0008);
        check_req("t1.req2", 2, 32'h1c00_0010);
        check_pair("t1.pair0", 0, 32'h1c00_0000, 2'b11);
        check_pair("t1.pair1", 1, 32'h1c00_0008, 2'b11);

        // 2: redirect with two requests outstanding
        reqs.delete();
        got.delete();
        resp_hold        = 1'b1;
        icache_req_ready = 1'b1;
        step(3);
        check("t2.inflight_reqs", 64'(reqs.size()), 64'd2);
        reqs.delete();
        branch_mistaken = 1'b1;
        correct_target  = 32'h1c00_0104;
        #1;
        check("t2.bypass_addr", 64'(icache_req_addr), 64'h1c00_0100);
        step(1);
        branch_mistaken = 1'b0;
        resp_hold       = 1'b0;
        step(10);
        icache_req_ready = 1'b0;
        wait_idle("t2.idle");
        check_req("t2.req0", 0, 32'h1c00_0100);
        check_pair("t2.pair0", 0, 32'h1c00_0104, 2'b01);
        check_pair("t2.pair1", 1, 32'h1c00_0108, 2'b11);

        // 3: ibuf stalled for 10 cycles
        redirect_idle(32'h1c00_1000);
        reqs.delete();
        got.delete();
        ibuf_ready       = 1'b0;
        icache_req_ready = 1'b1;
        step(5);
        check("t3.head_mid", 64'(ibuf_pc), 64'h1c00_1000);
        step(5);
        check("t3.req_count", 64'(reqs.size()), 64'd2);
        check("t3.req_valid", 64'(icache_req_valid), 64'd0);
        check("t3.ibuf_valid", 64'(ibuf_valid), 64'd1);
        check("t3.head_end", 64'(ibuf_pc), 64'h1c00_1000);
        ibuf_ready = 1'b1;
        step(8);
        icache_req_ready = 1'b0;
        wait_idle("t3.idle");
        check_pair("t3.pair0", 0, 32'h1c00_1000, 2'b11);
        check_pair("t3.pair1", 1, 32'h1c00_1008, 2'b11);
        check_pair("t3.pair2", 2, 32'h1c00_1010, 2'b11);

        // 4: redirect coincident with resp_fire and req_fire
        redirect_idle(32'h1c00_2000);
        reqs.delete();
        got.delete();
        icache_req_ready = 1'b1;
        step(1);
        branch_mistaken = 1'b1;
        correct_target  = 32'h1c00_3000;
        #1;
        check("t4.req_valid", 64'(icache_req_valid), 64'd1);
        check("t4.req_addr", 64'(icache_req_addr), 64'h1c00_3000);
        check("t4.resp_valid", 64'(icache_resp_valid), 64'd1);
        check("t4.ibuf_forced0", 64'(ibuf_valid), 64'd0);
        step(1);
        branch_mistaken = 1'b0;
        step(6);
        icache_req_ready = 1'b0;
        wait_idle("t4.idle");
        check_req("t4.req0", 0, 32'h1c00_2000);
        check_req("t4.req1", 1, 32'h1c00_3000);
        check_req("t4.req2", 2, 32'h1c00_3008);
        check_pair("t4.pair0", 0, 32'h1c00_3000, 2'b11);
        check_pair("t4.pair1", 1, 32'h1c00_3008, 2'b11);

        // 5: three back-to-back redirects under traffic
        icache_req_ready = 1'b1;
        step(3);
        got.delete();
        branch_mistaken = 1'b1;
        correct_target  = 32'h1c00_4000;
        step(1);
        correct_target  = 32'h1c00_5000;
        step(1);
        correct_target  = 32'h1c00_6004;
        step(1);
        branch_mistaken = 1'b0;
        step(10);
        icache_req_ready = 1'b0;
        wait_idle("t5.idle");
        check_pair("t5.pair0", 0, 32'h1c00_6004, 2'b01);
        check_pair("t5.pair1", 1, 32'h1c00_6008, 2'b11);
        check("t5.req_valid_idle", 64'(icache_req_valid), 64'd1);

        // 6: address wrap, then asynchronous reset mid-burst
        redirect_idle(32'hffff_fff8);
        reqs.delete();
        got.delete();
        icache_req_ready = 1'b1;
        step(4);
        check_req("t6.req0", 0, 32'hffff_fff8);
        check_req("t6.req1", 1, 32'h0000_0000);
        check_pair("t6.pair0", 0, 32'hffff_fff8, 2'b11);
        #1;
        resetn = 1'b0;
        #1;
        check("t6.rst_req_valid", 64'(icache_req_valid), 64'd0);
        check("t6.rst_req_addr", 64'(icache_req_addr), 64'd0);
        check("t6.rst_ibuf_valid", 64'(ibuf_valid), 64'd0);
        check("t6.rst_ibuf_pc", 64'(ibuf_pc), 64'd0);
        check("t6.rst_ibuf_mask", 64'(ibuf_mask), 64'd0);
        step(2);
        resetn = 1'b1;
        #1;
        check("t6.post_rst_valid", 64'(icache_req_valid), 64'd1);
        check("t6.post_rst_addr", 64'(icache_req_addr), 64'h1c00_0000);
        icache_req_ready = 1'b0;
        wait_idle("t6.idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
